// File: rtl/eth_fcs_appender.sv
// Ethernet II FCS appender: pads short frames to MIN_LEN and appends the reflected CRC-32 FCS.
// Padding is built only when ETH_FCS_PAD_EN is defined; otherwise every frame just gets its FCS.
module eth_fcs_appender #(
  parameter int MIN_LEN = 60,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_tdata_i,
  input  logic [3:0]  in_tkeep_i,
  input  logic        in_tvld_i,
  input  logic        in_tlast_i,
  output logic        in_trdy_o,
  output logic [31:0] out_tdata_o,
  output logic [3:0]  out_tkeep_o,
  output logic        out_tvld_o,
  output logic        out_tlast_o,
  input  logic        out_rdy_i
);

  // state    | meaning
  // DATA     | frame words pass through to the output register
  // PAD      | emitting zero words until MIN_LEN bytes are out
  // FCS_TAIL | emitting the remaining 1..4 FCS bytes with tlast
`ifdef ETH_FCS_PAD_EN
  typedef enum logic [1:0] {DATA, PAD, FCS_TAIL} state_t;
`else
  typedef enum logic [1:0] {DATA, FCS_TAIL} state_t;
`endif

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] d,
                                           input logic [3:0] keep);
    logic [31:0] r;
    r = c;
    for (int l = 0; l < 4; l++) if (keep[l]) r = crc_byte(r, d[8*l +: 8]);
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] fcs_q, fcs_d;
  logic [2:0]  pend_q, pend_d;
  logic        run_q;
  logic        out_adv, in_acc, ld, ld_last;
  logic [31:0] ld_data, data_m, crc_data, fcs_data;
  logic [3:0]  ld_keep, pend_keep;
  logic [2:0]  k;

`ifdef ETH_FCS_PAD_EN
  localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next, cnt_plus4;
  logic [CNT_W:0]   cnt_sum;
  logic [31:0]      crc_pad, crc_zero;
  logic             short_frame, pad_done;
`endif

  assign out_adv   = !out_tvld_o || out_rdy_i;
  assign in_trdy_o = run_q && (state_q == DATA) && out_adv;
  assign in_acc    = in_tvld_i && in_trdy_o;

  always_comb begin
    k = 3'(in_tkeep_i[0]) + 3'(in_tkeep_i[1]) + 3'(in_tkeep_i[2]) + 3'(in_tkeep_i[3]);
    for (int l = 0; l < 4; l++) data_m[8*l +: 8] = in_tkeep_i[l] ? in_tdata_i[8*l +: 8] : 8'h00;
    crc_data = crc_word(crc_q, in_tdata_i, in_tkeep_i);
    fcs_data = ~crc_data;
    case (pend_q)
      3'd1:    pend_keep = 4'b0001;
      3'd2:    pend_keep = 4'b0011;
      3'd3:    pend_keep = 4'b0111;
      default: pend_keep = 4'b1111;
    endcase
  end

`ifdef ETH_FCS_PAD_EN
  always_comb begin
    cnt_sum     = {1'b0, cnt_q} + (CNT_W+1)'(k);
    cnt_next    = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    cnt_plus4   = cnt_q + CNT_W'(4);
    short_frame = cnt_next < MIN_LEN_C;
    pad_done    = cnt_plus4 >= MIN_LEN_C;
    crc_pad     = crc_word(crc_q, data_m, 4'hF);
    crc_zero    = crc_word(crc_q, 32'h0, 4'hF);
  end
`endif

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    fcs_d   = fcs_q;
    pend_d  = pend_q;
    ld      = 1'b0;
    ld_data = 32'h0;
    ld_keep = 4'h0;
    ld_last = 1'b0;
`ifdef ETH_FCS_PAD_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      DATA: if (in_acc) begin
        ld = 1'b1;
        if (!in_tlast_i) begin
          ld_data = in_tdata_i;
          ld_keep = in_tkeep_i;
          crc_d   = crc_data;
`ifdef ETH_FCS_PAD_EN
          cnt_d   = cnt_next;
        end else if (short_frame) begin
          // Unused lanes of the last word become the first pad bytes.
          ld_data = data_m;
          ld_keep = 4'hF;
          if (pad_done) begin
            state_d = FCS_TAIL;
            fcs_d   = ~crc_pad;
            pend_d  = 3'd4;
            crc_d   = CRC_INIT;
            cnt_d   = '0;
          end else begin
            state_d = PAD;
            crc_d   = crc_pad;
            cnt_d   = cnt_plus4;
          end
`endif
        end else begin
          // FCS fills lanes k..3; the rest (k bytes, all 4 when k=4) goes in the tail word.
          ld_data = data_m | (fcs_data << {k, 3'b000});
          ld_keep = 4'hF;
          fcs_d   = fcs_data >> {3'd4 - k, 3'b000};
          pend_d  = k;
          state_d = FCS_TAIL;
          crc_d   = CRC_INIT;
`ifdef ETH_FCS_PAD_EN
          cnt_d   = '0;
`endif
        end
      end
`ifdef ETH_FCS_PAD_EN
      PAD: if (out_adv) begin
        ld      = 1'b1;
        ld_keep = 4'hF;
        crc_d   = crc_zero;
        cnt_d   = cnt_plus4;
        if (pad_done) begin
          state_d = FCS_TAIL;
          fcs_d   = ~crc_zero;
          pend_d  = 3'd4;
          crc_d   = CRC_INIT;
          cnt_d   = '0;
        end
      end
`endif
      FCS_TAIL: if (out_adv) begin
        ld      = 1'b1;
        ld_data = fcs_q;
        ld_keep = pend_keep;
        ld_last = 1'b1;
        state_d = DATA;
      end
      default: state_d = DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q       <= 1'b0;
      state_q     <= DATA;
      crc_q       <= CRC_INIT;
      fcs_q       <= 32'h0;
      pend_q      <= 3'd0;
      out_tvld_o  <= 1'b0;
      out_tlast_o <= 1'b0;
      out_tkeep_o <= 4'h0;
      out_tdata_o <= 32'h0;
`ifdef ETH_FCS_PAD_EN
      cnt_q       <= '0;
`endif
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      crc_q   <= crc_d;
      fcs_q   <= fcs_d;
      pend_q  <= pend_d;
`ifdef ETH_FCS_PAD_EN
      cnt_q   <= cnt_d;
`endif
      if (ld) begin
        out_tvld_o  <= 1'b1;
        out_tdata_o <= ld_data;
        out_tkeep_o <= ld_keep;
        out_tlast_o <= ld_last;
      end else if (out_rdy_i) begin
        out_tvld_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_fcs_appender.sv
// Self-checking bench for eth_fcs_appender; the byte-level reference model honours ETH_FCS_PAD_EN.
module tb_eth_fcs_appender;

  localparam int MIN_LEN = 60;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_tdata_i = '0;
  logic [3:0]  in_tkeep_i = '0;
  logic        in_tvld_i = 1'b0;
  logic        in_tlast_i = 1'b0;
  logic        in_trdy_o;
  logic [31:0] out_tdata_o;
  logic [3:0]  out_tkeep_o;
  logic        out_tvld_o;
  logic        out_tlast_o;
  logic        out_rdy_i = 1'b1;

  int    tests_run = 0;
  int    tests_failed = 0;
  int    stall_errs = 0;
  bit    rdy_rand = 1'b0;
  bit    prev_stall = 1'b0;
  word_t prev_w;
  word_t exp_q[$];
  word_t obs_q[$];

  eth_fcs_appender #(.MIN_LEN(MIN_LEN), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_tdata_i(in_tdata_i), .in_tkeep_i(in_tkeep_i), .in_tvld_i(in_tvld_i),
    .in_tlast_i(in_tlast_i), .in_trdy_o(in_trdy_o),
    .out_tdata_o(out_tdata_o), .out_tkeep_o(out_tkeep_o), .out_tvld_o(out_tvld_o),
    .out_tlast_o(out_tlast_o), .out_rdy_i(out_rdy_i)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    out_rdy_i = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
  end

  // Output monitor: records transfers (invalid lanes masked) and stall stability.
  initial begin
    word_t cur, m;
    forever begin
      @(negedge clk);
      cur = {out_tdata_o, out_tkeep_o, out_tlast_o};
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (!out_tvld_o || cur !== prev_w)) stall_errs++;
        prev_stall = out_tvld_o && !out_rdy_i;
        prev_w = cur;
        if (out_tvld_o && out_rdy_i) begin
          m = cur;
          for (int l = 0; l < 4; l++) if (!m.keep[l]) m.data[8*l +: 8] = 8'h00;
          obs_q.push_back(m);
        end
      end
    end
  end

  function automatic logic [31:0] crc32(input byte_q_t s);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (s[i]) begin
      c ^= {24'h0, s[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic model_frame(input byte_q_t f);
    byte_q_t     s;
    logic [31:0] fcs;
    word_t       w;
    s = f;
`ifdef ETH_FCS_PAD_EN
    while (s.size() < MIN_LEN) s.push_back(8'h00);
`endif
    fcs = crc32(s);
    for (int i = 0; i < 4; i++) s.push_back(fcs[8*i +: 8]);
    for (int i = 0; i < s.size(); i += 4) begin
      w = '0;
      for (int l = 0; l < 4; l++)
        if (i + l < s.size()) begin
          w.data[8*l +: 8] = s[i + l];
          w.keep[l] = 1'b1;
        end
      w.last = (i + 4 >= s.size());
      exp_q.push_back(w);
    end
  endtask

  function automatic byte_q_t rand_frame(input int len);
    byte_q_t f;
    for (int i = 0; i < len; i++) f.push_back(8'($urandom));
    return f;
  endfunction

  // Entered and left at posedge+1. stop_words >= 0 aborts the frame before its tlast.
  task automatic send_frame(input byte_q_t f, input int gap_pct, input int stop_words);
    int nw, cyc;
    bit acc;
    nw = (f.size() + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      if (stop_words >= 0 && w >= stop_words) break;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_tvld_i = 1'b0;
        @(posedge clk);
        #1;
      end
      in_tkeep_i = '0;
      for (int l = 0; l < 4; l++)
        if (4*w + l < f.size()) begin
          in_tdata_i[8*l +: 8] = f[4*w + l];
          in_tkeep_i[l] = 1'b1;
        end else begin
          in_tdata_i[8*l +: 8] = 8'($urandom);
        end
      in_tlast_i = (w == nw - 1);
      in_tvld_i  = 1'b1;
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 2000) begin
        @(negedge clk);
        acc = in_trdy_o;
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!acc) begin
        tests_run++;
        tests_failed++;
        $display("FAIL send_timeout word %0d: in_trdy_o stayed 0, required 1", w);
        in_tvld_i = 1'b0;
        return;
      end
    end
    in_tvld_i  = 1'b0;
    in_tlast_i = 1'b0;
    if (stop_words < 0) model_frame(f);
  endtask

  task automatic wait_drain(output bit ok);
    int cyc = 0;
    while (obs_q.size() < exp_q.size() && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    ok = (obs_q.size() >= exp_q.size());
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (10) begin
      @(posedge clk);
      #1;
      in_tdata_i = $urandom;
      in_tkeep_i = 4'hF;
      in_tvld_i  = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({in_trdy_o, out_tvld_o, out_tlast_o, out_tkeep_o, out_tdata_o} !== 39'h0) begin
        tests_failed++;
        $display("FAIL reset_outputs: got trdy=%b vld=%b last=%b keep=%h data=%h, required all 0",
                 in_trdy_o, out_tvld_o, out_tlast_o, out_tkeep_o, out_tdata_o);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_tvld_i = 1'b0;
  endtask

  task automatic test_known_vector();
    byte_q_t f;
    bit ok;
    word_t kv[4];
    f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    rdy_rand = 1'b0;
    send_frame(f, 0, -1);
    wait_drain(ok);
`ifndef ETH_FCS_PAD_EN
    kv[0] = {32'h3433_3231, 4'hF, 1'b0};
    kv[1] = {32'h3837_3635, 4'hF, 1'b0};
    kv[2] = {32'hF439_2639, 4'hF, 1'b0};
    kv[3] = {32'h0000_00CB, 4'h1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= obs_q.size()) begin
        tests_failed++;
        $display("FAIL known_const word %0d: missing, required %h", i, kv[i]);
      end else if (obs_q[i] !== kv[i]) begin
        tests_failed++;
        $display("FAIL known_const word %0d: got %h required %h", i, obs_q[i], kv[i]);
      end
    end
`endif
    tests_run++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL known_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests_run++;
      if (i >= obs_q.size()) begin
        tests_failed++;
        $display("FAIL known_word %0d: missing, required %h", i, exp_q[i]);
      end else if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL known_word %0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Back-to-back frames around the MIN_LEN boundary and every tail width.
  task automatic test_boundary_lengths();
    int lens[12] = '{64, 63, 62, 61, 60, 59, 57, 56, 5, 4, 1, 65};
    bit ok;
    rdy_rand = 1'b0;
    foreach (lens[j]) send_frame(rand_frame(lens[j]), 0, -1);
    wait_drain(ok);
    tests_run++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL boundary_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests_run++;
      if (i >= obs_q.size()) begin
        tests_failed++;
        $display("FAIL boundary_word %0d: missing, required %h", i, exp_q[i]);
      end else if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL boundary_word %0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random_traffic();
    bit ok;
    rdy_rand = 1'b1;
    stall_errs = 0;
    for (int n = 0; n < 200; n++) send_frame(rand_frame($urandom_range(300, 1)), 25, -1);
    wait_drain(ok);
    rdy_rand = 1'b0;
    tests_run++;
    if (stall_errs !== 0) begin
      tests_failed++;
      $display("FAIL random_stall: got %0d stall changes, required 0", stall_errs);
    end
    tests_run++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL random_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests_run++;
      if (i >= obs_q.size()) begin
        tests_failed++;
        $display("FAIL random_word %0d: missing, required %h", i, exp_q[i]);
      end else if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL random_word %0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int nlast = 0;
    rdy_rand = 1'b0;
    send_frame(rand_frame(100), 0, 13);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_tvld_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_vld: got out_tvld_o=%b, required 0", out_tvld_o);
    end
    foreach (obs_q[i]) if (obs_q[i].last) nlast++;
    tests_run++;
    if (nlast != 0) begin
      tests_failed++;
      $display("FAIL midreset_tlast: got %0d tlast words from dropped frame, required 0", nlast);
    end
    obs_q.delete();
    @(posedge clk);
    #1;
    send_frame(rand_frame(70), 0, -1);
    wait_drain(ok);
    tests_run++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL midreset_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests_run++;
      if (i >= obs_q.size()) begin
        tests_failed++;
        $display("FAIL midreset_word %0d: missing, required %h", i, exp_q[i]);
      end else if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL midreset_word %0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_boundary_lengths();
    test_random_traffic();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
